// File: rtl/intr_ctrl.sv
// Interrupt controller: edge-detected pending latch, mask/global enable, fixed
// priority select and a single request/ack/eret service sequence.
module intr_ctrl #(
    parameter int          N_IRQ      = 4,
    parameter logic [31:0] VEC_BASE   = 32'h0000_4180,
    parameter logic [31:0] VEC_STRIDE = 32'h0000_0020
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_IRQ-1:0] irq_in,
    input  logic             int_ack,
    input  logic             eret,
    input  logic             cfg_we,
    input  logic [1:0]       cfg_addr,
    input  logic [31:0]      cfg_wdata,
    output logic [31:0]      cfg_rdata,
    output logic             int_req,
    output logic [31:0]      int_vec,
    output logic [2:0]       int_id,
    output logic             in_service
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        SERVICE
    } state_t;

    state_t           state;
    logic [N_IRQ-1:0] irq_q;
    logic [N_IRQ-1:0] mask;
    logic [N_IRQ-1:0] pending;
    logic             ie;

    logic [N_IRQ-1:0] rise;
    logic [N_IRQ-1:0] elig;
    logic [N_IRQ-1:0] id_onehot;
    logic [N_IRQ-1:0] clr;
    logic [N_IRQ-1:0] pending_next;
    logic [2:0]       prio_id;
    logic             cur_elig;
    logic             ack_now;
    logic             unused_wdata;

    assign unused_wdata = ^cfg_wdata;

    function automatic logic [2:0] prio(input logic [N_IRQ-1:0] v);
        logic       found;
        logic [2:0] id;
        found = 1'b0;
        id    = '0;
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            if (!found && v[i]) begin
                id    = 3'(i);
                found = 1'b1;
            end
        end
        return id;
    endfunction

    always_comb begin
        rise    = irq_in & ~irq_q;
        elig    = pending & mask & {N_IRQ{ie}};
        prio_id = prio(elig);
        for (int unsigned i = 0; i < N_IRQ; i++) begin
            id_onehot[i] = (int_id == 3'(i));
        end
        cur_elig = |(elig & id_onehot);
        ack_now  = (state == REQ) && int_ack;
        clr      = '0;
        if (cfg_we && cfg_addr == 2'd1) begin
            clr = cfg_wdata[N_IRQ-1:0];
        end
        if (ack_now) begin
            clr = clr | id_onehot;
        end
        // a rising edge in the same cycle as a clear keeps the bit set
        pending_next = (pending & ~clr) | rise;
    end

    always_comb begin
        cfg_rdata = '0;
        case (cfg_addr)
            2'd0:    cfg_rdata = 32'(mask);
            2'd1:    cfg_rdata = 32'(pending);
            2'd2:    cfg_rdata = {25'b0, int_id, 2'b0, in_service, ie};
            default: cfg_rdata = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_q   <= '0;
            pending <= '0;
            mask    <= '0;
            ie      <= 1'b0;
        end else begin
            irq_q   <= irq_in;
            pending <= pending_next;
            if (cfg_we && cfg_addr == 2'd0) begin
                mask <= cfg_wdata[N_IRQ-1:0];
            end
            if (cfg_we && cfg_addr == 2'd2) begin
                ie <= cfg_wdata[0];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            int_req    <= 1'b0;
            int_vec    <= VEC_BASE;
            int_id     <= '0;
            in_service <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (elig != '0) begin
                        state   <= REQ;
                        int_req <= 1'b1;
                        int_id  <= prio_id;
                        int_vec <= VEC_BASE + 32'(prio_id) * VEC_STRIDE;
                    end
                end
                REQ: begin
                    if (int_ack) begin
                        state      <= SERVICE;
                        int_req    <= 1'b0;
                        in_service <= 1'b1;
                    end else if (!cur_elig) begin
                        state   <= IDLE;
                        int_req <= 1'b0;
                    end
                end
                SERVICE: begin
                    if (eret) begin
                        state      <= IDLE;
                        in_service <= 1'b0;
                    end
                end
                default: begin
                    state      <= IDLE;
                    int_req    <= 1'b0;
                    in_service <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_intr_ctrl.sv
// Directed bench for intr_ctrl: each step advances one clock and checks
// registered outputs and config reads against hand-computed values.
module tb_intr_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  irq_in;
    logic        int_ack;
    logic        eret;
    logic        cfg_we;
    logic [1:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic [31:0] cfg_rdata;
    logic        int_req;
    logic [31:0] int_vec;
    logic [2:0]  int_id;
    logic        in_service;

    int total  = 0;
    int passed = 0;

    intr_ctrl #(
        .N_IRQ(4),
        .VEC_BASE(32'h0000_4180),
        .VEC_STRIDE(32'h0000_0020)
    ) dut (
        .clk(clk),
        .rst(rst),
        .irq_in(irq_in),
        .int_ack(int_ack),
        .eret(eret),
        .cfg_we(cfg_we),
        .cfg_addr(cfg_addr),
        .cfg_wdata(cfg_wdata),
        .cfg_rdata(cfg_rdata),
        .int_req(int_req),
        .int_vec(int_vec),
        .int_id(int_id),
        .in_service(in_service)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input string tag, input logic [1:0] addr, input logic [31:0] exp);
        cfg_addr = addr;
        #1;
        chk(tag, cfg_rdata, exp);
    endtask

    task automatic cfg_write(input logic [1:0] addr, input logic [31:0] data);
        cfg_we    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        tick();
        cfg_we    = 1'b0;
        cfg_wdata = '0;
    endtask

    task automatic outs(input string tag, input logic req, input logic [2:0] id,
                        input logic [31:0] vec, input logic svc);
        chk({tag, ".req"}, 32'(int_req), 32'(req));
        chk({tag, ".id"}, 32'(int_id), 32'(id));
        chk({tag, ".vec"}, int_vec, vec);
        chk({tag, ".svc"}, 32'(in_service), 32'(svc));
    endtask

    initial begin
        rst = 1'b1; irq_in = '0; int_ack = 1'b0; eret = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0;
        tick(); tick();
        outs("reset", 1'b0, 3'd0, 32'h4180, 1'b0);
        rd("reset.mask", 2'd0, 32'h0);
        rd("reset.pend", 2'd1, 32'h0);
        rd("reset.stat", 2'd2, 32'h0);
        rst = 1'b0;
        tick();

        // 1: single line, full service cycle
        cfg_write(2'd0, 32'h2);
        cfg_write(2'd2, 32'h1);
        irq_in = 4'b0010;
        tick();
        chk("t1.req_k", 32'(int_req), 32'h0);
        rd("t1.pend_k", 2'd1, 32'h2);
        irq_in = '0;
        tick();
        outs("t1.req", 1'b1, 3'd1, 32'h41A0, 1'b0);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        outs("t1.ack", 1'b0, 3'd1, 32'h41A0, 1'b1);
        rd("t1.pend_ack", 2'd1, 32'h0);
        rd("t1.stat", 2'd2, 32'h13);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("t1.eret.svc", 32'(in_service), 32'h0);
        tick();
        chk("t1.idle.req", 32'(int_req), 32'h0);

        // 2: simultaneous edges, lowest index first
        cfg_write(2'd0, 32'hF);
        irq_in = 4'b1001;
        tick();
        irq_in = '0;
        tick();
        outs("t2.first", 1'b1, 3'd0, 32'h4180, 1'b0);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        rd("t2.pend", 2'd1, 32'h8);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("t2.reentry.req", 32'(int_req), 32'h0);
        tick();
        outs("t2.second", 1'b1, 3'd3, 32'h41E0, 1'b0);
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        eret = 1'b1;
        tick();
        eret = 1'b0;

        // 3: withdraw on W1C, then ack beating the withdraw
        irq_in = 4'b0100;
        tick();
        irq_in = '0;
        tick();
        outs("t3.req", 1'b1, 3'd2, 32'h41C0, 1'b0);
        cfg_write(2'd1, 32'h4);
        chk("t3.w1c.req", 32'(int_req), 32'h1);
        rd("t3.w1c.pend", 2'd1, 32'h0);
        tick();
        chk("t3.withdraw.req", 32'(int_req), 32'h0);
        chk("t3.withdraw.svc", 32'(in_service), 32'h0);
        tick();
        chk("t3.idle.req", 32'(int_req), 32'h0);
        irq_in = 4'b0100;
        tick();
        irq_in = '0;
        tick();
        chk("t3b.req", 32'(int_req), 32'h1);
        int_ack = 1'b1;
        cfg_write(2'd1, 32'h4);
        int_ack = 1'b0;
        outs("t3b.ackwins", 1'b0, 3'd2, 32'h41C0, 1'b1);
        eret = 1'b1;
        tick();
        eret = 1'b0;

        // 4: edge during service waits for eret
        irq_in = 4'b0001;
        tick();
        irq_in = '0;
        tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("t4.svc", 32'(in_service), 32'h1);
        irq_in = 4'b0010;
        tick();
        irq_in = '0;
        rd("t4.pend", 2'd1, 32'h2);
        tick();
        chk("t4.hold.req", 32'(int_req), 32'h0);
        tick();
        chk("t4.hold2.req", 32'(int_req), 32'h0);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        chk("t4.eret.req", 32'(int_req), 32'h0);
        chk("t4.eret.svc", 32'(in_service), 32'h0);
        tick();
        outs("t4.rise", 1'b1, 3'd1, 32'h41A0, 1'b0);

        // 5: asynchronous reset in REQ, then in SERVICE
        rst = 1'b1;
        #1;
        outs("t5.rst_req", 1'b0, 3'd0, 32'h4180, 1'b0);
        tick();
        rst = 1'b0;
        cfg_write(2'd0, 32'hF);
        cfg_write(2'd2, 32'h1);
        irq_in = 4'b0100;
        tick();
        irq_in = '0;
        tick();
        int_ack = 1'b1;
        tick();
        int_ack = 1'b0;
        chk("t5.svc", 32'(in_service), 32'h1);
        rst = 1'b1;
        #1;
        outs("t5.rst_svc", 1'b0, 3'd0, 32'h4180, 1'b0);
        tick();
        rst = 1'b0;
        tick(); tick();
        rd("t5.mask", 2'd0, 32'h0);
        rd("t5.pend", 2'd1, 32'h0);
        chk("t5.norq", 32'(int_req), 32'h0);

        // 6: IE gates requests but not pending; register width/reserved address
        cfg_write(2'd0, 32'hFFFF_FFFF);
        rd("t6.mask", 2'd0, 32'hF);
        cfg_write(2'd3, 32'hFFFF_FFFF);
        rd("t6.rsvd", 2'd3, 32'h0);
        irq_in = 4'b0100;
        tick();
        irq_in = '0;
        tick();
        rd("t6.pend", 2'd1, 32'h4);
        chk("t6.ie0.req", 32'(int_req), 32'h0);
        tick();
        chk("t6.ie0.req2", 32'(int_req), 32'h0);
        cfg_write(2'd2, 32'h1);
        chk("t6.ie1.req", 32'(int_req), 32'h0);
        tick();
        outs("t6.rise", 1'b1, 3'd2, 32'h41C0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
